// File: rtl/load_store_unit.sv
// MEM-stage data-memory interface: one valid/ready request per access, waits for the load
// response, and returns sign/zero-extended load data with a one-cycle Done pulse.
module load_store_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              WE,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic              Busy,
    output logic              Done,
    output logic [31:0]       ReadData,
    output logic              Misaligned,
    output logic              Timeout,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e           state_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic        start_illegal;
    logic [3:0]  start_be;
    logic [31:0] start_wdata;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] rsp_data;
    logic        timeout_hit;

    // Decode of the incoming access, evaluated in the Start cycle.
    always_comb begin
        if (WE) begin
            start_illegal = Funct3[2] || (Funct3[1:0] == 2'b11);
        end else begin
            start_illegal = (Funct3[1:0] == 2'b11) || (Funct3 == 3'b110);
        end
        case (Funct3[1:0])
            2'b01:   if (Addr[0]) start_illegal = 1'b1;
            2'b10:   if (Addr[1:0] != 2'b00) start_illegal = 1'b1;
            default: ;
        endcase

        start_be    = 4'b1111;
        start_wdata = WriteData;
        if (WE) begin
            case (Funct3[1:0])
                2'b00: begin
                    start_be    = 4'b0001 << Addr[1:0];
                    start_wdata = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    start_be    = Addr[1] ? 4'b1100 : 4'b0011;
                    start_wdata = {2{WriteData[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (offset_q)
            2'd0:    rsp_byte = mem_rdata[7:0];
            2'd1:    rsp_byte = mem_rdata[15:8];
            2'd2:    rsp_byte = mem_rdata[23:16];
            default: rsp_byte = mem_rdata[31:24];
        endcase
        rsp_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  rsp_data = {{24{rsp_byte[7]}}, rsp_byte};
            3'b001:  rsp_data = {{16{rsp_half[15]}}, rsp_half};
            3'b100:  rsp_data = {24'b0, rsp_byte};
            3'b101:  rsp_data = {16'b0, rsp_half};
            default: rsp_data = mem_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (32'(wait_cnt_q) == TIMEOUT - 1);

    // Stall starts combinationally in the Start cycle so the pipeline freezes immediately.
    assign Busy = (state_q == StReq) || (state_q == StWait) || ((state_q == StIdle) && Start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            wait_cnt_q    <= '0;
            Done          <= 1'b0;
            ReadData      <= 32'b0;
            Misaligned    <= 1'b0;
            Timeout       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_be        <= 4'b0;
            mem_wdata     <= 32'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        we_q      <= WE;
                        funct3_q  <= Funct3;
                        offset_q  <= Addr[1:0];
                        mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
                        mem_we    <= WE;
                        mem_be    <= start_be;
                        mem_wdata <= start_wdata;
                        if (start_illegal) begin
                            state_q    <= StDone;
                            Done       <= 1'b1;
                            Misaligned <= 1'b1;
                            ReadData   <= 32'b0;
                        end else begin
                            state_q       <= StReq;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wait_cnt_q    <= '0;
                        if (we_q) begin
                            state_q <= StDone;
                            Done    <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rsp_valid) begin
                        state_q  <= StDone;
                        Done     <= 1'b1;
                        ReadData <= rsp_data;
                    end else if (timeout_hit) begin
                        state_q  <= StDone;
                        Done     <= 1'b1;
                        Timeout  <= 1'b1;
                        ReadData <= 32'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    Done       <= 1'b0;
                    Misaligned <= 1'b0;
                    Timeout    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a behavioural access model.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset, Start, WE;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WriteData;
    logic        Busy, Done, Misaligned, Timeout;
    logic [31:0] ReadData;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .Start(Start), .WE(WE), .Funct3(Funct3), .Addr(Addr),
        .WriteData(WriteData), .Busy(Busy), .Done(Done), .ReadData(ReadData),
        .Misaligned(Misaligned), .Timeout(Timeout), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (we) return (f3 > 2) || (f3 == 1 && a % 2 != 0) || (f3 == 2 && a % 4 != 0);
        case (f3)
            0, 4:    return 0;
            1, 5:    return a % 2 != 0;
            2:       return a % 4 != 0;
            default: return 1;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic we, input logic [2:0] f3,
                                          input logic [31:0] a);
        if (!we || f3 == 2) return 4'hF;
        if (f3 == 0) return 4'(1 << (a % 4));
        return (a % 4 >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            0:       return {{24{s[7]}}, s[7:0]};
            1:       return {{16{s[15]}}, s[15:0]};
            4:       return s & 32'hFF;
            5:       return s & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // One complete access; rdly = cycles with ready low, sdly = WAIT cycle of the response.
    task automatic acc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int rdly, input int sdly,
                       input logic [31:0] rdata);
        int          done_cyc;
        logic [31:0] rd_obs;
        logic        to_obs, mis_obs, busy_obs;
        bit          exp_to;
        Start = 1; WE = we; Funct3 = f3; Addr = a; WriteData = wd;
        @(negedge clk);
        check("busy_start", Busy, 1);
        tick();
        Start = 0; WE = 1'($urandom); Funct3 = 3'($urandom); Addr = $urandom;
        WriteData = $urandom;
        if (ref_illegal(we, f3, a)) begin
            @(negedge clk);
            check("illegal_done", {Done, Misaligned, Timeout, mem_req_valid, Busy}, 5'b11000);
            tick();
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                mem_req_ready = (i == rdly);
                mem_rsp_valid = 1'($urandom);
                @(negedge clk);
                check("req_ctl", {mem_req_valid, mem_we, mem_be, Busy, Done},
                      {1'b1, we, ref_be(we, f3, a), 1'b1, 1'b0});
                check("req_addr", mem_addr, a & ~32'h3);
                if (we) check("req_wdata", mem_wdata, ref_wdata(f3, wd));
                tick();
            end
            mem_req_ready = 0;
            mem_rsp_valid = 0;
            if (we) begin
                @(negedge clk);
                check("store_done", {Done, Misaligned, Timeout, mem_req_valid, Busy}, 5'b10000);
                tick();
            end else begin
                done_cyc = -1;
                rd_obs = 'x; to_obs = 'x; mis_obs = 'x; busy_obs = 'x;
                exp_to = !(sdly < TMO);
                for (int c = 0; c < 20 && done_cyc < 0; c++) begin
                    mem_rsp_valid = (c == sdly);
                    mem_rdata = (c == sdly) ? rdata : $urandom;
                    @(negedge clk);
                    if (Done) begin
                        done_cyc = c; rd_obs = ReadData; to_obs = Timeout;
                        mis_obs = Misaligned; busy_obs = Busy;
                    end
                    tick();
                end
                mem_rsp_valid = 0;
                check("load_latency", 32'(done_cyc), 32'(exp_to ? TMO : sdly + 1));
                check("load_data", rd_obs, exp_to ? 32'h0 : ref_load(f3, int'(a % 4), rdata));
                check("load_flags", {to_obs, mis_obs, busy_obs}, {exp_to, 2'b00});
            end
        end
        @(negedge clk);
        check("done_pulse", {Done, Busy}, 2'b00);
        tick();
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check(tag, {Busy, Done, Misaligned, Timeout, mem_req_valid, mem_we, mem_be, ReadData,
                    mem_addr, mem_wdata}, '0);
    endtask

    initial begin
        reset = 1; Start = 0; WE = 0; Funct3 = 0; Addr = 0; WriteData = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        tick(); tick();
        check_zero("reset_outputs");
        tick();
        reset = 0;

        acc(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF7F);
        acc(1'b0, 3'b101, 32'h2002, 32'h0, 0, 1, 32'hBEEF_1234);
        acc(1'b0, 3'b001, 32'h2002, 32'h0, 1, 0, 32'hBEEF_1234);
        acc(1'b1, 3'b000, 32'h0011, 32'hAB, 3, 0, 32'h0);
        acc(1'b1, 3'b001, 32'h0102, 32'h1234_5678, 0, 0, 32'h0);
        acc(1'b1, 3'b010, 32'h0104, 32'hCAFE_F00D, 1, 0, 32'h0);
        acc(1'b0, 3'b010, 32'h0006, 32'h0, 0, 0, 32'h0);
        acc(1'b0, 3'b011, 32'h0000, 32'h0, 0, 0, 32'h0);
        acc(1'b1, 3'b011, 32'h0000, 32'h0, 0, 0, 32'h0);
        acc(1'b0, 3'b010, 32'h0008, 32'h0, 0, 99, 32'h0);
        acc(1'b0, 3'b100, 32'h0009, 32'h0, 0, 3, 32'h1234_F056);

        // Reset while waiting for a load response; the late response must be ignored.
        Start = 1; WE = 0; Funct3 = 3'b010; Addr = 32'h40; tick();
        Start = 0; mem_req_ready = 1; tick();
        mem_req_ready = 0; reset = 1; tick();
        reset = 0; mem_rsp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
        check_zero("reset_wait_outputs");
        tick();
        mem_rsp_valid = 0;
        check_zero("reset_late_rsp");
        tick();

        // Reset while a store request is stalled.
        Start = 1; WE = 1; Funct3 = 3'b010; Addr = 32'h80; tick();
        Start = 0;
        @(negedge clk);
        check("req_before_reset", mem_req_valid, 1);
        tick();
        reset = 1; tick();
        reset = 0;
        @(negedge clk);
        check("req_after_reset", {mem_req_valid, Busy, Done}, 3'b000);
        tick();
        acc(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF7F);

        for (int n = 0; n < 60; n++) begin
            acc(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 5), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
